// File: rtl/router_pkg.sv
// ============================================================================
// router_pkg : shared constants for the 1x3 router control FSM
// Revision   : 1.0
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  localparam logic [2:0] DA  = 3'd0;
  localparam logic [2:0] LFD = 3'd1;
  localparam logic [2:0] LD  = 3'd2;
  localparam logic [2:0] FFS = 3'd3;
  localparam logic [2:0] LAF = 3'd4;
  localparam logic [2:0] LP  = 3'd5;
  localparam logic [2:0] CPE = 3'd6;
  localparam logic [2:0] WTE = 3'd7;

endpackage

`default_nettype wire

// File: rtl/router_fsm.sv
// ============================================================================
// router_fsm : Moore control FSM sequencing header/payload/parity per packet
// Revision   : 1.0
// ============================================================================
`default_nettype none

module router_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy
);

  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;

  assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};

  // addr_q never holds ADDR_INVALID, so the per-channel selects stay in range.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (soft_reset[addr_q]) begin
      state_d = DA;
    end else begin
      case (state_q)
        DA: begin
          if (pkt_valid && (data_in != ADDR_INVALID)) begin
            addr_d  = data_in;
            state_d = fifo_empty[data_in] ? LFD : WTE;
          end
        end
        LFD: state_d = LD;
        LD: begin
          if (fifo_full)       state_d = FFS;
          else if (!pkt_valid) state_d = LP;
        end
        FFS: begin
          if (!fifo_full) state_d = LAF;
        end
        LAF: begin
          if (parity_done)           state_d = DA;
          else if (low_packet_valid) state_d = LP;
          else                       state_d = LD;
        end
        LP:  state_d = CPE;
        CPE: state_d = fifo_full ? FFS : DA;
        WTE: begin
          if (fifo_empty[addr_q]) state_d = LFD;
        end
        default: state_d = DA;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DA;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign detect_add    = (state_q == DA);
  assign lfd_state     = (state_q == LFD);
  assign ld_state      = (state_q == LD);
  assign laf_state     = (state_q == LAF);
  assign full_state    = (state_q == FFS);
  assign rst_int_reg   = (state_q == CPE);
  assign write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
  assign busy          = !((state_q == DA) || (state_q == LD));

endmodule

`default_nettype wire

// File: tb/tb_router_fsm.sv
// ============================================================================
// tb_router_fsm : vector-table bench for router_fsm
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_router_fsm;

  // Expected output bundle: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0010;
  localparam logic [7:0] O_LAF = 8'b0001_0011;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LP  = 8'b0000_0011;
  localparam logic [7:0] O_CPE = 8'b0000_0101;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  typedef struct {
    logic       rstn;
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic       pd;
    logic       lpv;
    logic [2:0] emp;
    logic [2:0] sr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];

  always #5 clock = ~clock;

  router_fsm #(.NUM_PORTS(3)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .fifo_empty_0     (fifo_empty_0),
    .fifo_empty_1     (fifo_empty_1),
    .fifo_empty_2     (fifo_empty_2),
    .soft_reset_0     (soft_reset_0),
    .soft_reset_1     (soft_reset_1),
    .soft_reset_2     (soft_reset_2),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .write_enb_reg    (write_enb_reg),
    .busy             (busy)
  );

  task automatic add(input logic rstn, input logic pv, input logic [1:0] din,
                     input logic ff, input logic pd, input logic lpv,
                     input logic [2:0] emp, input logic [2:0] sr,
                     input logic [7:0] exp, input string name);
    vec_t v;
    v.rstn = rstn; v.pv = pv; v.din = din; v.ff = ff; v.pd = pd; v.lpv = lpv;
    v.emp = emp; v.sr = sr; v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] got;
    resetn           = v.rstn;
    pkt_valid        = v.pv;
    data_in          = v.din;
    fifo_full        = v.ff;
    parity_done      = v.pd;
    low_packet_valid = v.lpv;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = v.sr;
    @(posedge clock);
    #1;
    got = {detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy};
    n_cmp++;
    if (got !== v.exp) begin
      n_bad++;
      $display("FAIL %s: got outputs %b, required %b", v.name, got, v.exp);
    end
  endtask

  initial begin
    vec_t v;
    // reset
    add(0, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DA,  "reset_c1");
    add(0, 1, 2'd1, 1, 0, 0, 3'b111, 3'b000, O_DA,  "reset_c2");
    // addr 1, three payload bytes, no stalls
    add(1, 1, 2'd1, 0, 0, 0, 3'b111, 3'b000, O_LFD, "p1_lfd");
    add(1, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LD,  "p1_ld1");
    add(1, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LD,  "p1_ld2");
    add(1, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LD,  "p1_ld3");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LP,  "p1_lp");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_CPE, "p1_cpe");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DA,  "p1_da");
    // addr 0, 4-cycle full stall, then LAF paths
    add(1, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LFD, "p2_lfd");
    add(1, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LD,  "p2_ld");
    add(1, 0, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FFS, "p2_ffs1_fullprio");
    add(1, 1, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FFS, "p2_ffs2");
    add(1, 1, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FFS, "p2_ffs3");
    add(1, 1, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FFS, "p2_ffs4");
    add(1, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LAF, "p2_laf1");
    add(1, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LD,  "p2_laf_to_ld");
    add(1, 1, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FFS, "p2_ffs5");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LAF, "p2_laf2");
    add(1, 0, 2'd0, 0, 0, 1, 3'b111, 3'b000, O_LP,  "p2_laf_to_lp");
    add(1, 0, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_CPE, "p2_cpe");
    add(1, 0, 2'd0, 1, 0, 0, 3'b111, 3'b000, O_FFS, "p2_cpe_to_ffs");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LAF, "p2_laf3");
    add(1, 0, 2'd0, 0, 1, 1, 3'b111, 3'b000, O_DA,  "p2_laf_to_da");
    // addr 2 with a non-empty FIFO: wait five cycles
    add(1, 1, 2'd2, 0, 0, 0, 3'b011, 3'b000, O_WTE, "p3_wte1");
    for (int i = 0; i < 4; i++)
      add(1, 0, 2'd0, 0, 0, 0, 3'b011, 3'b000, O_WTE, "p3_wte_hold");
    add(1, 1, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LFD, "p3_lfd");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LD,  "p3_ld");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_LP,  "p3_lp");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_CPE, "p3_cpe");
    add(1, 0, 2'd0, 0, 0, 0, 3'b111, 3'b000, O_DA,  "p3_da");

    foreach (vq[i]) run_vec(vq[i]);

    // invalid header: stay in DA, latched address (2) untouched
    v = '{rstn:1, pv:1, din:2'd3, ff:0, pd:0, lpv:0, emp:3'b111, sr:3'b000,
          exp:O_DA, name:"bad_addr_hold"};
    run_vec(v);
    run_vec(v);
    n_cmp++;
    if (dut.addr_q !== 2'd2) begin
      n_bad++;
      $display("FAIL bad_addr_latch: got addr_q %0d, required 2", dut.addr_q);
    end

    // soft reset: only the selected channel's reset matters
    v = '{rstn:1, pv:1, din:2'd0, ff:0, pd:0, lpv:0, emp:3'b111, sr:3'b000,
          exp:O_LFD, name:"sr_lfd"};
    run_vec(v);
    v.exp = O_LD;  v.name = "sr_ld";          run_vec(v);
    v.sr = 3'b010; v.name = "sr_other_ign";   run_vec(v);
    v.sr = 3'b110; v.name = "sr_others_ign";  run_vec(v);
    v.sr = 3'b001; v.exp = O_DA; v.name = "sr_own_to_da"; run_vec(v);

    // soft reset out of WTE on channel 1
    v = '{rstn:1, pv:1, din:2'd1, ff:0, pd:0, lpv:0, emp:3'b101, sr:3'b000,
          exp:O_WTE, name:"sr_wte"};
    run_vec(v);
    v.pv = 0; v.sr = 3'b010; v.exp = O_DA; v.name = "sr_wte_to_da"; run_vec(v);

    // resetn overrides a pending transition
    v = '{rstn:1, pv:1, din:2'd2, ff:0, pd:0, lpv:0, emp:3'b111, sr:3'b000,
          exp:O_LFD, name:"rst_lfd"};
    run_vec(v);
    v.rstn = 0; v.exp = O_DA; v.name = "rst_from_lfd"; run_vec(v);
    n_cmp++;
    if (dut.addr_q !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_addr: got addr_q %0d, required 0", dut.addr_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
